// File: rtl/factorial_pkg.sv
// Shared constants for the factorial DMA master: slave register map, address nibbles,
// job size limit and the DMA controller state encoding.
package factorial_pkg;

   localparam int unsigned FACDMA_MAX_N = 8;
   localparam logic [3:0]  SLV_NIBBLE   = 4'h1;
   localparam logic [3:0]  MEM_NIBBLE   = 4'h0;

   // Factorial slave register offsets
   localparam logic [3:0] OFS_OP_CLEAR = 4'h0;
   localparam logic [3:0] OFS_INT_EN   = 4'h1;
   localparam logic [3:0] OFS_OP_START = 4'h2;
   localparam logic [3:0] OFS_N_PUSH   = 4'h3;
   localparam logic [3:0] OFS_RES_POP  = 4'h4;
   localparam logic [3:0] OFS_OP_DONE  = 4'h9;

   typedef enum logic [3:0] {
      StIdle  = 4'd0,
      StReq   = 4'd1,
      StSetIe = 4'd2,
      StRdOp  = 4'd3,
      StWrN   = 4'd4,
      StStart = 4'd5,
      StWait  = 4'd6,
      StPop   = 4'd7,
      StWrRes = 4'd8,
      StClear = 4'd9,
      StFin   = 4'd10
   } dma_state_e;

   // Limit a requested operand count to the slave FIFO depth
   function automatic logic [3:0] clamp_count(logic [3:0] req, logic [3:0] max_cnt);
      return (req > max_cnt) ? max_cnt : req;
   endfunction

endpackage

// File: rtl/facdma_res_buf.sv
// Result buffer for the factorial DMA master: DEPTH x WIDTH register file filled in
// arrival order and drained in the same order. Pointers restart on clr.
module facdma_res_buf
   import factorial_pkg::*;
#(
   parameter int unsigned DEPTH = 2 * FACDMA_MAX_N,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;

   // Pointer bookkeeping; clr restarts both for a new job
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage array; contents are only meaningful below wr_ptr_q, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/factorial_dma_master.sv
// Bus master feeding the factorial slave: reads operands from memory, pushes them into the
// slave, starts it, drains the 64-bit results (hi word then lo word) into a local buffer,
// writes them back to memory and clears the slave.
// Build option FACDMA_POLL_EN: completion is detected by polling the slave op_done register
// every 4th cycle instead of using the interrupt input, and int_en is never written.
module factorial_dma_master
   import factorial_pkg::*;
#(
   parameter int unsigned MAX_N    = FACDMA_MAX_N,
   parameter logic [3:0]  SLV_BASE = SLV_NIBBLE,
   parameter logic [3:0]  MEM_BASE = MEM_NIBBLE
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_start,
   input  logic [3:0]  cfg_src,
   input  logic [3:0]  cfg_dst,
   input  logic [3:0]  cfg_count,
   output logic        M_req,
   input  logic        M_grant,
   output logic        M_sel,
   output logic        M_wr,
   output logic [7:0]  M_address,
   output logic [31:0] M_dout,
   input  logic [31:0] M_din,
   input  logic        interrupt,
   output logic        busy,
   output logic        done
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_N);

   dma_state_e  state_q, state_d;
   logic [3:0]  src_q, dst_q, cnt_q;
   logic [4:0]  idx_q, idx_d;     // operand index, pop phase or write-back index
   logic [31:0] op_q, op_d;
   logic [4:0]  words;            // result words for this job
   logic        start_job;
   logic        buf_clr, buf_we, buf_re;
   logic [31:0] buf_rdata;

   assign words = {cnt_q, 1'b0};

`ifdef FACDMA_POLL_EN
   logic [1:0] poll_q;
   logic       unused_irq;
   assign unused_irq = interrupt;

   // Poll phase counter, restarted each time WAIT is left
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                poll_q <= '0;
      else if (state_q == StWait)  poll_q <= poll_q + 2'd1;
      else                         poll_q <= '0;
   end
`endif

   // State, index and job configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         op_q    <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         if (start_job) begin
            src_q <= cfg_src;
            dst_q <= cfg_dst;
            cnt_q <= clamp_count(cfg_count, MAX_CNT);
         end
      end
   end

   // Next-state and bus outputs; every bus step advances only on a granted cycle
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      op_d      = op_q;
      start_job = 1'b0;
      buf_clr   = 1'b0;
      buf_we    = 1'b0;
      buf_re    = 1'b0;
      M_req     = 1'b0;
      M_sel     = 1'b0;
      M_wr      = 1'b0;
      M_address = '0;
      M_dout    = '0;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cfg_start) begin
               start_job = 1'b1;
               buf_clr   = 1'b1;
               idx_d     = '0;
               state_d   = (cfg_count == 4'd0) ? StFin : StReq;
            end
         end
         StReq: begin
            busy  = 1'b1;
            M_req = 1'b1;
`ifdef FACDMA_POLL_EN
            if (M_grant) state_d = StRdOp;
`else
            if (M_grant) state_d = StSetIe;
`endif
         end
         StSetIe: begin
            busy      = 1'b1;
            M_req     = 1'b1;
            M_sel     = 1'b1;
            M_wr      = 1'b1;
            M_address = {SLV_BASE, OFS_INT_EN};
            M_dout    = 32'd1;
            if (M_grant) state_d = StRdOp;
         end
         StRdOp: begin
            busy      = 1'b1;
            M_req     = 1'b1;
            M_sel     = 1'b1;
            M_address = {MEM_BASE, src_q + idx_q[3:0]};
            if (M_grant) begin
               op_d    = M_din;
               state_d = StWrN;
            end
         end
         StWrN: begin
            busy      = 1'b1;
            M_req     = 1'b1;
            M_sel     = 1'b1;
            M_wr      = 1'b1;
            M_address = {SLV_BASE, OFS_N_PUSH};
            M_dout    = op_q;
            if (M_grant) begin
               if (idx_q + 5'd1 < {1'b0, cnt_q}) begin
                  idx_d   = idx_q + 5'd1;
                  state_d = StRdOp;
               end else begin
                  idx_d   = '0;
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            busy      = 1'b1;
            M_req     = 1'b1;
            M_sel     = 1'b1;
            M_wr      = 1'b1;
            M_address = {SLV_BASE, OFS_OP_START};
            M_dout    = 32'd1;
            if (M_grant) state_d = StWait;
         end
         StWait: begin
            busy  = 1'b1;
            M_req = 1'b1;
`ifdef FACDMA_POLL_EN
            if (poll_q == 2'd3) begin
               M_sel     = 1'b1;
               M_address = {SLV_BASE, OFS_OP_DONE};
               if (M_grant && M_din[0]) state_d = StPop;
            end
`else
            if (interrupt) state_d = StPop;
`endif
         end
         StPop: begin
            // Phase 0 is address only; each later phase captures the word addressed one
            // granted cycle earlier. The final phase captures without a new address.
            busy      = 1'b1;
            M_req     = 1'b1;
            M_sel     = (idx_q < words);
            M_address = {SLV_BASE, OFS_RES_POP};
            if (M_grant) begin
               buf_we = (idx_q != 5'd0);
               if (idx_q == words) begin
                  idx_d   = '0;
                  state_d = StWrRes;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         StWrRes: begin
            busy      = 1'b1;
            M_req     = 1'b1;
            M_sel     = 1'b1;
            M_wr      = 1'b1;
            M_address = {MEM_BASE, dst_q + idx_q[3:0]};
            M_dout    = buf_rdata;
            if (M_grant) begin
               buf_re = 1'b1;
               if (idx_q == words - 5'd1) begin
                  idx_d   = '0;
                  state_d = StClear;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         StClear: begin
            busy      = 1'b1;
            M_req     = 1'b1;
            M_sel     = 1'b1;
            M_wr      = 1'b1;
            M_address = {SLV_BASE, OFS_OP_CLEAR};
            M_dout    = 32'd1;
            if (M_grant) state_d = StFin;
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   facdma_res_buf #(
      .DEPTH (2 * MAX_N),
      .WIDTH (32)
   ) u_res_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (buf_clr),
      .wr_en   (buf_we),
      .wr_data (M_din),
      .rd_en   (buf_re),
      .rd_data (buf_rdata)
   );

endmodule

// File: tb/tb_factorial_dma_master.sv
// Bench for factorial_dma_master: behavioural memory and factorial slave on the bus,
// expected write-back stream queued per job and checked by a bus monitor.
module tb_factorial_dma_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic [3:0]  cfg_src = '0, cfg_dst = '0, cfg_count = '0;
   logic        M_req, M_sel, M_wr;
   logic        M_grant = 1'b1;
   logic [7:0]  M_address;
   logic [31:0] M_dout, M_din;
   logic        interrupt;
   logic        busy, done;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   factorial_dma_master dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_start (cfg_start),
      .cfg_src   (cfg_src),
      .cfg_dst   (cfg_dst),
      .cfg_count (cfg_count),
      .M_req     (M_req),
      .M_grant   (M_grant),
      .M_sel     (M_sel),
      .M_wr      (M_wr),
      .M_address (M_address),
      .M_dout    (M_dout),
      .M_din     (M_din),
      .interrupt (interrupt),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic longint unsigned fact(int n);
      longint unsigned f = 1;
      for (int k = 2; k <= n; k++) f = f * longint'(k);
      return f;
   endfunction

   // Memory and slave model state
   logic [31:0] mem [16];
   logic [31:0] ref_mem [16];
   logic        int_en = 1'b0, op_done = 1'b0;
   logic [31:0] rdata = '0;
   logic [31:0] nfifo[$];
   logic [31:0] resq[$];
   int          lat = 0;

   typedef struct {logic [7:0] addr; logic [31:0] data;} wr_t;
   wr_t exp_q[$];

   logic        p_v = 1'b0, p_wr = 1'b0;
   logic [7:0]  p_a = '0;
   logic [31:0] p_d = '0;
   logic        bd_we = 1'b0;
   logic [3:0]  bd_a = '0;
   logic [31:0] bd_d = '0;
   int          done_cnt = 0;
   bit          req_seen = 0;
   int          gmode = 0;

   always_comb begin
      if (M_address[7:4] == 4'h0)      M_din = mem[M_address[3:0]];
      else if (M_address[3:0] == 4'h9) M_din = {31'b0, op_done};
      else if (M_address[3:0] == 4'h1) M_din = {31'b0, int_en};
      else                             M_din = rdata;
   end

`ifdef FACDMA_POLL_EN
   assign interrupt = 1'b0;
`else
   assign interrupt = op_done & int_en;
`endif

   // Grant pattern, changed just after each rising edge
   always begin
      @(posedge clk);
      #1;
      case (gmode)
         0:       M_grant = 1'b1;
         1:       M_grant = ~M_grant;
         default: M_grant = 1'($urandom_range(0, 1));
      endcase
   end

   // Bus monitor: samples the cycle's transfer and checks memory writes against the queue
   always @(negedge clk) begin
      p_v  = reset_n && M_req && M_grant && M_sel;
      p_wr = M_wr;
      p_a  = M_address;
      p_d  = M_dout;
      if (M_req) req_seen = 1;
      if (done) done_cnt++;
      if (p_v && p_wr && p_a[7:4] == 4'h0) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected write: addr %0h data %0h, none queued", p_a, p_d);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr addr", 64'(p_a), 64'(e.addr));
            check("wr data", 64'(p_d), 64'(e.data));
         end
      end
   end

   // Memory and factorial slave behaviour for the transfer sampled in this cycle
   always @(posedge clk) begin
      if (!reset_n) begin
         int_en  <= 1'b0;
         op_done <= 1'b0;
         rdata   <= '0;
         nfifo.delete();
         resq.delete();
         lat = 0;
      end else begin
         if (bd_we) mem[bd_a] <= bd_d;
         if (lat > 0) begin
            lat--;
            if (lat == 0) begin
               foreach (nfifo[i]) begin
                  longint unsigned f;
                  f = fact(int'(nfifo[i]));
                  resq.push_back(f[63:32]);
                  resq.push_back(f[31:0]);
               end
               nfifo.delete();
               op_done <= 1'b1;
            end
         end
         if (p_v) begin
            if (p_a[7:4] == 4'h0) begin
               if (p_wr) mem[p_a[3:0]] <= p_d;
            end else begin
               case (p_a[3:0])
                  4'h0: if (p_wr) begin
                     check("clear only when done", 64'(op_done), 64'd1);
                     op_done <= 1'b0;
                  end
                  4'h1: if (p_wr) int_en <= p_d[0];
                  4'h2: if (p_wr) lat = int'($urandom_range(1, 6));
                  4'h3: if (p_wr) nfifo.push_back(p_d);
                  4'h4: if (!p_wr) begin
                     check("pop has data", 64'(resq.size() != 0), 64'd1);
                     if (resq.size() != 0) rdata <= resq.pop_front();
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic load(int a, logic [31:0] d);
      bd_a = a[3:0];
      bd_d = d;
      bd_we = 1'b1;
      ref_mem[a[3:0]] = d;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   task automatic load_ops(int src, int cnt);
      int n;
      n = (cnt > 8) ? 8 : cnt;
      for (int i = 0; i < n; i++) load((src + i) % 16, 32'($urandom_range(0, 20)));
   endtask

   // Reference: all operands read first, then hi/lo words of each factorial written in order
   task automatic expect_job(int src, int dst, int cnt);
      int n;
      logic [31:0] w[$];
      n = (cnt > 8) ? 8 : cnt;
      for (int i = 0; i < n; i++) begin
         longint unsigned f;
         f = fact(int'(ref_mem[(src + i) % 16]));
         w.push_back(f[63:32]);
         w.push_back(f[31:0]);
      end
      for (int j = 0; j < w.size(); j++) begin
         int a;
         wr_t e;
         a = (dst + j) % 16;
         e.addr = {4'h0, a[3:0]};
         e.data = w[j];
         exp_q.push_back(e);
         ref_mem[a] = w[j];
      end
   endtask

   task automatic pulse(int src, int dst, int cnt);
      cfg_src = src[3:0];
      cfg_dst = dst[3:0];
      cfg_count = cnt[3:0];
      cfg_start = 1'b1;
      @(posedge clk);
      #1 cfg_start = 1'b0;
   endtask

   task automatic finish_job(int d0);
      int c = 0;
      int nbad = 0;
      while (done_cnt == d0 && c < 3000) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("done before timeout", 64'(done_cnt != d0), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("single done pulse", 64'(done_cnt - d0), 64'd1);
      check("busy low after done", 64'(busy), 64'd0);
      check("all writes seen", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) nbad++;
      check("memory image", 64'(nbad), 64'd0);
      check("slave idle", {61'd0, op_done, resq.size() == 0, nfifo.size() == 0}, 64'd3);
   endtask

   task automatic job(int src, int dst, int cnt);
      int d0;
      d0 = done_cnt;
      expect_job(src, dst, cnt);
      pulse(src, dst, cnt);
      finish_job(d0);
   endtask

   initial begin
      logic [31:0] saved [16];
      int d0, c;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {19'd0, M_req, M_sel, M_wr, busy, done, M_address, M_dout}, 64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 16; i++) load(i, 32'd0);

      // Single operand, grant tied high
      gmode = 0;
      load(0, 32'd5);
      job(0, 4, 1);
      check("5! hi", 64'(mem[4]), 64'd0);
      check("5! lo", 64'(mem[5]), 64'd120);
`ifdef FACDMA_POLL_EN
      check("int_en untouched", 64'(int_en), 64'd0);
`else
      check("int_en written", 64'(int_en), 64'd1);
`endif

      // Three operands including the 64-bit limit 20!
      load(8, 32'd1);
      load(9, 32'd3);
      load(10, 32'd20);
      job(8, 2, 3);
      check("1! lo", 64'(mem[3]), 64'd1);
      check("3! lo", 64'(mem[5]), 64'd6);
      check("20! hi", 64'(mem[6]), 64'h21C3677C);
      check("20! lo", 64'(mem[7]), 64'h82B40000);

      // Alternating grant, then random grant with address wrap and overlapping ranges
      gmode = 1;
      load_ops(3, 5);
      job(3, 9, 5);
      gmode = 2;
      load_ops(14, 4);
      job(14, 12, 4);

      // Start while busy is ignored
      gmode = 0;
      load_ops(1, 2);
      d0 = done_cnt;
      expect_job(1, 5, 2);
      pulse(1, 5, 2);
      repeat (2) @(posedge clk);
      #1;
      pulse(7, 7, 6);
      finish_job(d0);
      d0 = done_cnt;
      repeat (10) @(posedge clk);
      #1;
      check("no second job", {62'd0, busy, done_cnt != d0}, 64'd0);

      // Zero count: done the cycle after start, no bus request
      req_seen = 0;
      cfg_count = 4'd0;
      cfg_start = 1'b1;
      @(negedge clk);
      check("zero cnt done early", 64'(done), 64'd0);
      @(posedge clk);
      #1 cfg_start = 1'b0;
      @(negedge clk);
      check("zero cnt done", 64'(done), 64'd1);
      @(negedge clk);
      check("zero cnt done width", 64'(done), 64'd0);
      check("zero cnt no req", 64'(req_seen), 64'd0);

      // Reset during result pop, then a clean job
      gmode = 2;
      load_ops(4, 6);
      saved = ref_mem;
      expect_job(4, 0, 6);
      pulse(4, 0, 6);
      c = 0;
      @(negedge clk);
      while (!(M_sel && !M_wr && M_address == 8'h14) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      check("reached pop", 64'(c < 3000), 64'd1);
      reset_n = 1'b0;
      #1;
      check("outputs in reset", {19'd0, M_req, M_sel, M_wr, busy, done, M_address, M_dout}, 64'd0);
      exp_q.delete();
      ref_mem = saved;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      job(4, 0, 6);

      // Random jobs, counts above the limit included
      for (int r = 0; r < 8; r++) begin
         int src, dst, cnt;
         gmode = int'($urandom_range(0, 2));
         src = int'($urandom_range(0, 15));
         dst = int'($urandom_range(0, 15));
         cnt = int'($urandom_range(1, 15));
         load_ops(src, cnt);
         job(src, dst, cnt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
